// File: rtl/wb_result_checker.sv
// Writeback shadow-register checker: snoops MIPS writebacks during a run, then scans
// the shadow file against a programmed expected table. Optional macro: WB_CHK_LASTWR_EN.
`timescale 1ns/1ps
module wb_result_checker #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_CYCLES = 90,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exp_valid,
  input  logic [ADDR_WIDTH-1:0] exp_reg,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_clear,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  wb_reg_write,
  input  logic [ADDR_WIDTH-1:0] wb_write_register,
  input  logic [DATA_WIDTH-1:0] wb_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic [ADDR_WIDTH-1:0] first_bad_reg,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  last_write_cycle
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0]  RUN_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] SCAN_LAST = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                  state_q, state_d;
  logic [NUM_REGS-1:0]     mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   exp_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   exp_d [NUM_REGS];
  logic [DATA_WIDTH-1:0]   shadow_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   shadow_d [NUM_REGS];
  logic [CNT_WIDTH-1:0]    cycle_count_q, cycle_count_d;
  logic [CNT_WIDTH-1:0]    mismatch_count_q, mismatch_count_d;
  logic [ADDR_WIDTH-1:0]   first_bad_reg_q, first_bad_reg_d;
  logic [ADDR_WIDTH-1:0]   scan_q, scan_d;
  logic                    timed_out_q, timed_out_d;
  logic                    wb_hit;

  assign wb_hit = wb_reg_write && (wb_write_register != '0);

  always_comb begin
    state_d          = state_q;
    mask_d           = mask_q;
    exp_d            = exp_q;
    shadow_d         = shadow_q;
    cycle_count_d    = cycle_count_q;
    mismatch_count_d = mismatch_count_q;
    first_bad_reg_d  = first_bad_reg_q;
    scan_d           = scan_q;
    timed_out_d      = timed_out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // Clear is applied before the load so a same-cycle entry survives.
        if (exp_clear) mask_d = '0;
        if (exp_valid) begin
          mask_d[exp_reg] = 1'b1;
          exp_d[exp_reg]  = exp_data;
        end
        if (start) begin
          state_d = S_RUN;
          for (int unsigned i = 0; i < NUM_REGS; i++) shadow_d[i] = '0;
          cycle_count_d    = '0;
          mismatch_count_d = '0;
          first_bad_reg_d  = '0;
          scan_d           = '0;
          timed_out_d      = 1'b0;
        end
      end
      S_RUN: begin
        cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
        if (wb_hit) shadow_d[wb_write_register] = wb_write_data;
        if (halt) begin
          state_d = S_CHECK;
        end else if (cycle_count_q == RUN_LAST) begin
          state_d     = S_CHECK;
          timed_out_d = 1'b1;
        end
      end
      S_CHECK: begin
        scan_d = scan_q + ADDR_WIDTH'(1);
        if (mask_q[scan_q] && (shadow_q[scan_q] != exp_q[scan_q])) begin
          // A zero count doubles as "no mismatch seen yet"; saturation never returns to 0.
          if (mismatch_count_q == '0) first_bad_reg_d = scan_q;
          if (mismatch_count_q != '1) mismatch_count_d = mismatch_count_q + CNT_WIDTH'(1);
        end
        if (scan_q == SCAN_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      mask_q           <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        exp_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      cycle_count_q    <= '0;
      mismatch_count_q <= '0;
      first_bad_reg_q  <= '0;
      scan_q           <= '0;
      timed_out_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      mask_q           <= mask_d;
      exp_q            <= exp_d;
      shadow_q         <= shadow_d;
      cycle_count_q    <= cycle_count_d;
      mismatch_count_q <= mismatch_count_d;
      first_bad_reg_q  <= first_bad_reg_d;
      scan_q           <= scan_d;
      timed_out_q      <= timed_out_d;
    end
  end

  assign busy           = (state_q == S_RUN) || (state_q == S_CHECK);
  assign done           = (state_q == S_DONE);
  assign pass           = done && (mismatch_count_q == '0);
  assign timed_out      = timed_out_q;
  assign mismatch_count = mismatch_count_q;
  assign first_bad_reg  = first_bad_reg_q;
  assign cycle_count    = cycle_count_q;

`ifdef WB_CHK_LASTWR_EN
  logic [CNT_WIDTH-1:0] stamp_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] stamp_d [NUM_REGS];

  always_comb begin
    stamp_d = stamp_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) stamp_d[i] = '0;
    end else if (state_q == S_RUN && wb_hit) begin
      stamp_d[wb_write_register] = cycle_count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) stamp_q[i] <= '0;
    end else begin
      stamp_q <= stamp_d;
    end
  end

  assign last_write_cycle = (done && !pass) ? stamp_q[first_bad_reg_q] : '0;
`else
  assign last_write_cycle = '0;
`endif
endmodule

// File: tb/tb_wb_result_checker.sv
// Directed bench for wb_result_checker: run-level reference model plus literal checks.
`timescale 1ns/1ps
module tb_wb_result_checker;
  logic        clk = 1'b0;
  logic        reset;
  logic        exp_valid, exp_clear, start, halt, wb_reg_write;
  logic [4:0]  exp_reg, wb_write_register;
  logic [31:0] exp_data, wb_write_data;
  logic        busy, done, pass, timed_out;
  logic [15:0] mismatch_count, cycle_count, last_write_cycle;
  logic [4:0]  first_bad_reg;

  int n_tests = 0;
  int n_fail  = 0;

  wb_result_checker #(
    .DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .MAX_CYCLES(90), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_reg(exp_reg), .exp_data(exp_data), .exp_clear(exp_clear),
    .start(start), .halt(halt),
    .wb_reg_write(wb_reg_write), .wb_write_register(wb_write_register),
    .wb_write_data(wb_write_data),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .mismatch_count(mismatch_count), .first_bad_reg(first_bad_reg),
    .cycle_count(cycle_count), .last_write_cycle(last_write_cycle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: phase 0=idle 1=run 2=check 3=done. Results are computed
  // once at end of run by a direct sweep over the arrays.
  int          m_phase, m_run_cycles, m_check_left, m_mism, m_first_bad;
  bit          m_timed_out;
  bit          m_mask   [32];
  logic [31:0] m_exp    [32];
  logic [31:0] m_shadow [32];
  int          m_stamp  [32];

  function automatic void model_results();
    m_mism = 0;
    m_first_bad = 0;
    for (int i = 31; i >= 0; i--)
      if (m_mask[i] && m_shadow[i] !== m_exp[i]) begin
        m_mism++;
        m_first_bad = i;
      end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_run_cycles = 0; m_check_left = 0; m_mism = 0; m_first_bad = 0;
      m_timed_out = 0;
      for (int i = 0; i < 32; i++) begin
        m_mask[i] = 0; m_exp[i] = '0; m_shadow[i] = '0; m_stamp[i] = 0;
      end
    end else begin
      case (m_phase)
        0, 3: begin
          if (exp_clear) for (int i = 0; i < 32; i++) m_mask[i] = 0;
          if (exp_valid) begin m_mask[exp_reg] = 1; m_exp[exp_reg] = exp_data; end
          if (start) begin
            m_phase = 1; m_run_cycles = 0; m_timed_out = 0; m_mism = 0; m_first_bad = 0;
            for (int i = 0; i < 32; i++) begin m_shadow[i] = '0; m_stamp[i] = 0; end
          end
        end
        1: begin
          if (wb_reg_write && wb_write_register != 0) begin
            m_shadow[wb_write_register] = wb_write_data;
            m_stamp[wb_write_register]  = m_run_cycles;
          end
          m_run_cycles++;
          if (halt || m_run_cycles == 90) begin
            m_phase = 2; m_check_left = 32; m_timed_out = !halt;
            model_results();
          end
        end
        default: begin
          m_check_left--;
          if (m_check_left == 0) m_phase = 3;
        end
      endcase
    end
  end

  int exp_lwc;
  always @(negedge clk) begin
    check("busy", busy, (m_phase == 1 || m_phase == 2));
    check("done", done, (m_phase == 3));
    check("cycle_count", cycle_count, m_run_cycles);
    check("timed_out", timed_out, m_timed_out);
    if (m_phase == 0 || m_phase == 3) begin
`ifdef WB_CHK_LASTWR_EN
      exp_lwc = (m_phase == 3 && m_mism != 0) ? m_stamp[m_first_bad] : 0;
`else
      exp_lwc = 0;
`endif
      check("pass", pass, (m_phase == 3 && m_mism == 0));
      check("mismatch_count", mismatch_count, m_mism);
      check("first_bad_reg", first_bad_reg, m_first_bad);
      check("last_write_cycle", last_write_cycle, exp_lwc);
    end
  end

  typedef struct { int k; logic [4:0] r; logic [31:0] d; } wr_t;
  wr_t prog[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input logic [4:0] r, input logic [31:0] d, input bit clr);
    exp_valid = 1; exp_reg = r; exp_data = d; exp_clear = clr;
    tick();
    exp_valid = 0; exp_clear = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // n RUN cycles; halt (if requested) in the last one; writes from prog by cycle index.
  task automatic run(input int n, input bit do_halt);
    for (int k = 0; k < n; k++) begin
      wb_reg_write = 0;
      foreach (prog[j]) if (prog[j].k == k) begin
        wb_reg_write = 1; wb_write_register = prog[j].r; wb_write_data = prog[j].d;
      end
      halt = do_halt && (k == n - 1);
      tick();
    end
    wb_reg_write = 0; halt = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    if (!done) check("done_timeout", 0, 1);
  endtask

  int lat;
  initial begin
    reset = 1; exp_valid = 0; exp_clear = 0; start = 0; halt = 0; wb_reg_write = 0;
    exp_reg = 0; exp_data = 0; wb_write_register = 0; wb_write_data = 0;
    #22 reset = 0;
    tick();
    check("reset_busy", busy, 0);
    check("reset_pass", pass, 0);

    // 1: all expectations met, halt in 20th RUN cycle
    load_exp(3, 32'd0, 0);
    load_exp(4, 32'd30, 0);
    load_exp(6, 32'hFFFFFFE1, 0);
    load_exp(8, 32'd80, 0);
    prog = '{'{2, 5'd3, 32'd0}, '{5, 5'd4, 32'd30}, '{9, 5'd6, 32'hFFFFFFE1},
             '{12, 5'd8, 32'd80}, '{15, 5'd1, 32'd5}};
    do_start();
    run(20, 1);
    wait_done(lat);
    check("t1_check_latency", lat, 32);
    check("t1_pass", pass, 1);
    check("t1_mismatch", mismatch_count, 0);
    check("t1_timed_out", timed_out, 0);
    check("t1_cycle_count", cycle_count, 20);

    // 2: $4 written with the wrong value in RUN cycle 5
    prog[1].d = 32'd31;
    do_start();
    run(20, 1);
    wait_done(lat);
    check("t2_pass", pass, 0);
    check("t2_mismatch", mismatch_count, 1);
    check("t2_first_bad", first_bad_reg, 4);
`ifdef WB_CHK_LASTWR_EN
    check("t2_last_write", last_write_cycle, 5);
`else
    check("t2_last_write", last_write_cycle, 0);
`endif

    // 3: timeout after 90 cycles; write in the final RUN cycle is captured
    load_exp(5, 32'd7, 1);
    prog = '{'{89, 5'd5, 32'd7}};
    do_start();
    run(90, 0);
    check("t3_busy_after_90", busy, 1);
    check("t3_timed_out", timed_out, 1);
    check("t3_cycle_count", cycle_count, 90);
    wait_done(lat);
    check("t3_pass", pass, 1);

    // 4: writes to register 0 are dropped
    load_exp(0, 32'd0, 1);
    prog = '{'{1, 5'd0, 32'hDEAD}};
    do_start();
    run(4, 1);
    wait_done(lat);
    check("t4_pass", pass, 1);
    check("t4_mismatch", mismatch_count, 0);

    // 5: reset at scan index 10, then empty-mask run
    load_exp(7, 32'd1, 1);
    prog.delete();
    do_start();
    run(1, 1);
    for (int i = 0; i < 10; i++) tick();
    reset = 1;
    @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_timed_out", timed_out, 0);
    check("t5_rst_cycle_count", cycle_count, 0);
    check("t5_rst_mismatch", mismatch_count, 0);
    #1 reset = 0;
    tick();
    do_start();
    run(5, 1);
    wait_done(lat);
    check("t5_pass", pass, 1);
    check("t5_cycle_count", cycle_count, 5);

    // 6: clear+load in DONE; exp load during RUN is ignored
    load_exp(2, 32'd20, 1);
    prog = '{'{3, 5'd2, 32'd20}};
    do_start();
    exp_valid = 1; exp_reg = 9; exp_data = 32'd123;
    tick();
    exp_valid = 0;
    run(5, 1);
    wait_done(lat);
    check("t6_pass", pass, 1);
    check("t6_mismatch", mismatch_count, 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
